// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the two-port RAM arbiter: access sizes, RAM write-enable
// one-hots, the GPIO byte location and the sequencer state type.
package ram_port_arbiter_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_ILL = 2'b11;

    localparam logic [2:0] WE_IDLE  = 3'b000;
    localparam logic [2:0] WE_WORD  = 3'b001;
    localparam logic [2:0] WE_HALF  = 3'b010;
    localparam logic [2:0] WE_BYTE  = 3'b100;

    localparam logic [31:0] GPIO_ADDR = 32'h0000_00a0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] size_we(input logic [1:0] size);
        case (size)
            SIZE_B:  return WE_BYTE;
            SIZE_H:  return WE_HALF;
            SIZE_W:  return WE_WORD;
            default: return WE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way grant: round-robin on a last-served pointer, or port 0 always wins
// when FIXED_PRIO is set. The grant is combinational and only offered while en=1.
module rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_r;   // 1 = port 1 was served last, so port 0 is favoured next

    // Pick one requester; a lone requester always wins.
    always_comb begin
        grant = 2'b00;
        if (!en) begin
            grant = 2'b00;
        end else if (req == 2'b11) begin
            grant = (FIXED_PRIO || last_r) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    // Remember which port was served on every accepted grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (grant != 2'b00) begin
            last_r <= grant[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one byte-addressed single-port RAM between two request/response ports.
// Each access runs IDLE -> ACCESS -> RESP; rejected requests skip ACCESS.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int MEM_BYTES   = 2048,
    parameter int FIXED_PRIO  = 0,
    parameter int ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic        p0_req_we,
    input  logic [1:0]  p0_req_size,
    input  logic        p0_req_signed,
    input  logic [31:0] p0_req_addr,
    input  logic [31:0] p0_req_wdata,
    output logic        p0_resp_valid,
    output logic [31:0] p0_resp_rdata,
    output logic        p0_resp_err,
    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic        p1_req_we,
    input  logic [1:0]  p1_req_size,
    input  logic        p1_req_signed,
    input  logic [31:0] p1_req_addr,
    input  logic [31:0] p1_req_wdata,
    output logic        p1_resp_valid,
    output logic [31:0] p1_resp_rdata,
    output logic        p1_resp_err,
    output logic [2:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_t      state_r;
    logic        port_r;
    logic        we_r;
    logic        signed_r;
    logic [1:0]  size_r;
    logic [2:0]  ram_we_r;

    logic [1:0]  grant_s;
    logic        sel_s;
    logic        req_we_s;
    logic        req_signed_s;
    logic [1:0]  req_size_s;
    logic [31:0] req_addr_s;
    logic [31:0] req_wdata_s;
    logic [2:0]  nbytes_s;
    logic        misalign_s;
    logic        err_s;
    logic [31:0] rdata_ext_s;

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO != 0)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_r == ST_IDLE),
        .req   ({p1_req_valid, p0_req_valid}),
        .grant (grant_s)
    );

    assign p0_req_ready = grant_s[0];
    assign p1_req_ready = grant_s[1];
    assign sel_s        = grant_s[1];

    // A write still in ACCESS when reset lands must not reach the RAM on that edge.
    assign ram_we = rst_n ? ram_we_r : WE_IDLE;

    // Route the granted port's request fields and classify the request.
    always_comb begin
        req_we_s     = p0_req_we;
        req_size_s   = p0_req_size;
        req_signed_s = p0_req_signed;
        req_addr_s   = p0_req_addr;
        req_wdata_s  = p0_req_wdata;
        if (sel_s) begin
            req_we_s     = p1_req_we;
            req_size_s   = p1_req_size;
            req_signed_s = p1_req_signed;
            req_addr_s   = p1_req_addr;
            req_wdata_s  = p1_req_wdata;
        end else begin
            req_we_s     = p0_req_we;
        end
        nbytes_s   = size_nbytes(req_size_s);
        misalign_s = (ALIGN_CHECK != 0) &&
                     (((req_size_s == SIZE_H) && req_addr_s[0]) ||
                      ((req_size_s == SIZE_W) && (req_addr_s[1:0] != 2'b00)));
        // 33-bit sum so addresses near 2^32 cannot wrap into range.
        err_s      = (req_size_s == SIZE_ILL) ||
                     (({1'b0, req_addr_s} + {30'b0, nbytes_s}) > 33'(MEM_BYTES)) ||
                     misalign_s;
    end

    // RAM returns the addressed byte in the top lane; right-align and extend.
    always_comb begin
        rdata_ext_s = 32'h0000_0000;
        case (size_r)
            SIZE_B:  rdata_ext_s = signed_r ? {{24{ram_rdata[31]}}, ram_rdata[31:24]}
                                            : {24'h00_0000, ram_rdata[31:24]};
            SIZE_H:  rdata_ext_s = signed_r ? {{16{ram_rdata[31]}}, ram_rdata[31:16]}
                                            : {16'h0000, ram_rdata[31:16]};
            SIZE_W:  rdata_ext_s = ram_rdata;
            default: rdata_ext_s = 32'h0000_0000;
        endcase
    end

    // Transaction sequencer with registered RAM and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            port_r        <= 1'b0;
            we_r          <= 1'b0;
            signed_r      <= 1'b0;
            size_r        <= SIZE_B;
            ram_we_r      <= WE_IDLE;
            ram_addr      <= 32'h0000_0000;
            ram_wdata     <= 32'h0000_0000;
            p0_resp_valid <= 1'b0;
            p0_resp_err   <= 1'b0;
            p0_resp_rdata <= 32'h0000_0000;
            p1_resp_valid <= 1'b0;
            p1_resp_err   <= 1'b0;
            p1_resp_rdata <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s != 2'b00) begin
                        port_r   <= sel_s;
                        we_r     <= req_we_s;
                        size_r   <= req_size_s;
                        signed_r <= req_signed_s;
                        if (err_s) begin
                            state_r       <= ST_RESP;
                            ram_we_r      <= WE_IDLE;
                            p0_resp_valid <= ~sel_s;
                            p0_resp_err   <= ~sel_s;
                            p1_resp_valid <= sel_s;
                            p1_resp_err   <= sel_s;
                        end else begin
                            state_r   <= ST_ACCESS;
                            ram_we_r  <= req_we_s ? size_we(req_size_s) : WE_IDLE;
                            ram_addr  <= req_addr_s;
                            ram_wdata <= req_wdata_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state_r       <= ST_RESP;
                    ram_we_r      <= WE_IDLE;
                    p0_resp_valid <= ~port_r;
                    p1_resp_valid <= port_r;
                    p0_resp_err   <= 1'b0;
                    p1_resp_err   <= 1'b0;
                    p0_resp_rdata <= (!port_r && !we_r) ? rdata_ext_s : 32'h0000_0000;
                    p1_resp_rdata <= ( port_r && !we_r) ? rdata_ext_s : 32'h0000_0000;
                end
                ST_RESP: begin
                    state_r       <= ST_IDLE;
                    p0_resp_valid <= 1'b0;
                    p0_resp_err   <= 1'b0;
                    p0_resp_rdata <= 32'h0000_0000;
                    p1_resp_valid <= 1'b0;
                    p1_resp_err   <= 1'b0;
                    p1_resp_rdata <= 32'h0000_0000;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    ram_we_r      <= WE_IDLE;
                    p0_resp_valid <= 1'b0;
                    p1_resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a byte RAM behind the DUT, a byte-array reference
// model, directed scenarios and randomized traffic; a second instance uses fixed priority.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    localparam int MEM = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        p0_req_valid = 1'b0, p0_req_ready, p0_req_we = 1'b0, p0_req_signed = 1'b0;
    logic [1:0]  p0_req_size = 2'b00;
    logic [31:0] p0_req_addr = 32'h0, p0_req_wdata = 32'h0;
    logic        p0_resp_valid, p0_resp_err;
    logic [31:0] p0_resp_rdata;
    logic        p1_req_valid = 1'b0, p1_req_ready, p1_req_we = 1'b0, p1_req_signed = 1'b0;
    logic [1:0]  p1_req_size = 2'b00;
    logic [31:0] p1_req_addr = 32'h0, p1_req_wdata = 32'h0;
    logic        p1_resp_valid, p1_resp_err;
    logic [31:0] p1_resp_rdata;
    logic [2:0]  ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic        f0_valid = 1'b0, f0_ready, f0_resp_valid, f0_resp_err;
    logic        f1_valid = 1'b0, f1_ready, f1_resp_valid, f1_resp_err;
    logic [31:0] f0_resp_rdata, f1_resp_rdata, f_ram_addr, f_ram_wdata;
    logic [2:0]  f_ram_we;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram     [0:MEM-1];
    logic [7:0] ref_mem [0:MEM-1];

    ram_port_arbiter #(.MEM_BYTES(MEM), .FIXED_PRIO(0), .ALIGN_CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_size(p0_req_size), .p0_req_signed(p0_req_signed), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
        .p0_resp_err(p0_resp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_size(p1_req_size), .p1_req_signed(p1_req_signed), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
        .p1_resp_err(p1_resp_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_port_arbiter #(.MEM_BYTES(MEM), .FIXED_PRIO(1), .ALIGN_CHECK(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(f0_valid), .p0_req_ready(f0_ready), .p0_req_we(1'b0),
        .p0_req_size(SIZE_W), .p0_req_signed(1'b0), .p0_req_addr(32'h10),
        .p0_req_wdata(32'h0), .p0_resp_valid(f0_resp_valid), .p0_resp_rdata(f0_resp_rdata),
        .p0_resp_err(f0_resp_err),
        .p1_req_valid(f1_valid), .p1_req_ready(f1_ready), .p1_req_we(1'b0),
        .p1_req_size(SIZE_B), .p1_req_signed(1'b0), .p1_req_addr(32'h20),
        .p1_req_wdata(32'h0), .p1_resp_valid(f1_resp_valid), .p1_resp_rdata(f1_resp_rdata),
        .p1_resp_err(f1_resp_err),
        .ram_we(f_ram_we), .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata), .ram_rdata(32'h0)
    );

    // Combinational big-endian RAM read
    always_comb begin
        ram_rdata = 32'h0;
        for (int i = 0; i < 4; i++)
            ram_rdata[8*(3-i) +: 8] = ((ram_addr + 32'(i)) < 32'(MEM)) ? ram[11'(ram_addr + 32'(i))] : 8'h00;
    end

    // RAM write port
    always @(posedge clk) begin
        case (ram_we)
            3'b001: for (int i = 0; i < 4; i++) ram[ram_addr[10:0] + 11'(i)] <= ram_wdata[8*(3-i) +: 8];
            3'b010: begin
                ram[ram_addr[10:0]]         <= ram_wdata[15:8];
                ram[ram_addr[10:0] + 11'd1] <= ram_wdata[7:0];
            end
            3'b100: ram[ram_addr[10:0]] <= ram_wdata[7:0];
            default: ;
        endcase
    end

    function automatic int nbytes_of(input logic [1:0] size);
        case (size)
            2'b00: return 1;
            2'b01: return 2;
            2'b10: return 4;
            default: return 0;
        endcase
    endfunction

    // Reference: what a request should do to a byte-addressed big-endian memory.
    task automatic model_access(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rdata);
        int n = nbytes_of(size);
        longint end_a = longint'(addr) + longint'(n);
        err = (size == 2'b11) || (end_a > MEM) ||
              (n == 2 && (addr % 2) != 0) || (n == 4 && (addr % 4) != 0);
        rdata = 32'h0;
        if (!err && we) begin
            for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * (n - 1 - i)));
        end else if (!err) begin
            for (int i = 0; i < n; i++) rdata = (rdata << 8) | 32'(ref_mem[int'(addr) + i]);
            if (sgn && n < 4 && rdata[8*n-1]) rdata = rdata | ~((32'd1 << (8 * n)) - 32'd1);
        end
    endtask

    task automatic check_mem(input string name);
        int bad = -1;
        for (int i = 0; i < MEM; i++)
            if (bad < 0 && ram[i] !== ref_mem[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL mem_%s: byte 0x%0h is %h, required %h", name, bad, ram[bad], ref_mem[bad]);
        end
    endtask

    task automatic drive_port(input int port, input logic v, input logic we, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req_valid = v; p0_req_we = we; p0_req_size = size;
            p0_req_signed = sgn; p0_req_addr = addr; p0_req_wdata = wdata;
        end else begin
            p1_req_valid = v; p1_req_we = we; p1_req_size = size;
            p1_req_signed = sgn; p1_req_addr = addr; p1_req_wdata = wdata;
        end
    endtask

    // One complete transaction on one port, checked cycle by cycle against the model.
    task automatic run_txn(input int port, input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic got_err, output logic [31:0] got_rdata);
        logic exp_err, rv, ov;
        logic [31:0] exp_rdata;
        logic [2:0] exp_we;
        int waited = 0;
        int pulses = 0;
        got_err = 1'bx;
        got_rdata = 32'hx;
        @(negedge clk);
        drive_port(port, 1'b1, we, size, sgn, addr, wdata);
        #1;
        while (!(port == 0 ? p0_req_ready : p1_req_ready) && waited < 10) begin
            @(negedge clk); #1; waited++;
        end
        checks++;
        if (waited >= 10) begin
            errors++;
            $display("FAIL accept_timeout: port%0d ready stayed 0, required 1", port);
            drive_port(port, 1'b0, we, size, sgn, addr, wdata);
            return;
        end
        model_access(we, size, sgn, addr, wdata, exp_err, exp_rdata);
        case (nbytes_of(size))
            1: exp_we = 3'b100;
            2: exp_we = 3'b010;
            4: exp_we = 3'b001;
            default: exp_we = 3'b000;
        endcase
        if (exp_err || !we) exp_we = 3'b000;
        @(posedge clk); #1;
        drive_port(port, 1'b0, we, size, sgn, addr, wdata);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            rv = (port == 0) ? p0_resp_valid : p1_resp_valid;
            ov = (port == 0) ? p1_resp_valid : p0_resp_valid;
            checks++;
            if (ram_we !== (k == 1 ? exp_we : 3'b000)) begin
                errors++;
                $display("FAIL ram_we: cycle %0d after accept got %b, required %b", k, ram_we, (k == 1 ? exp_we : 3'b000));
            end
            checks++;
            if (ov !== 1'b0) begin
                errors++;
                $display("FAIL wrong_port_resp: port%0d resp_valid=%b at cycle %0d, required 0", 1 - port, ov, k);
            end
            if (rv === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    got_err   = (port == 0) ? p0_resp_err : p1_resp_err;
                    got_rdata = (port == 0) ? p0_resp_rdata : p1_resp_rdata;
                    checks++;
                    if (k != (exp_err ? 1 : 2)) begin
                        errors++;
                        $display("FAIL latency: resp at cycle %0d, required %0d", k, (exp_err ? 1 : 2));
                    end
                    checks++;
                    if (got_err !== exp_err) begin
                        errors++;
                        $display("FAIL resp_err: addr %h size %b got %b, required %b", addr, size, got_err, exp_err);
                    end
                    checks++;
                    if (got_rdata !== exp_rdata) begin
                        errors++;
                        $display("FAIL resp_rdata: addr %h size %b got %h, required %h", addr, size, got_rdata, exp_rdata);
                    end
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL resp_pulses: port%0d got %0d pulses, required 1", port, pulses);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ram_we, ram_addr, ram_wdata} !== 67'h0) begin
            errors++;
            $display("FAIL reset_ram: we=%b addr=%h wdata=%h, required all 0", ram_we, ram_addr, ram_wdata);
        end
        checks++;
        if ({p0_resp_valid, p0_resp_err, p1_resp_valid, p1_resp_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_resp: flags %b, required 0000", {p0_resp_valid, p0_resp_err, p1_resp_valid, p1_resp_err});
        end
        checks++;
        if ({p0_resp_rdata, p1_resp_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: %h %h, required 0", p0_resp_rdata, p1_resp_rdata);
        end
        checks++;
        if ({p0_req_ready, p1_req_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: %b, required 00", {p0_req_ready, p1_req_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_write_read();
        logic e; logic [31:0] d;
        run_txn(0, 1'b1, SIZE_W, 1'b0, 32'h10, 32'hDEADBEEF, e, d);
        run_txn(0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, e, d);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_readback: got %h, required deadbeef", d);
        end
    endtask

    task automatic test_byte_half();
        logic e; logic [31:0] d;
        run_txn(0, 1'b1, SIZE_B, 1'b0, 32'h13, 32'h80, e, d);
        run_txn(0, 1'b0, SIZE_B, 1'b1, 32'h13, 32'h0, e, d);
        checks++;
        if (d !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL signed_byte: got %h, required ffffff80", d);
        end
        run_txn(1, 1'b0, SIZE_H, 1'b0, 32'h12, 32'h0, e, d);
        checks++;
        if (d !== 32'h0000BE80) begin
            errors++;
            $display("FAIL unsigned_half: got %h, required 0000be80", d);
        end
    endtask

    task automatic test_arbitration();
        int order[$];
        int f0_cnt = 0;
        int f1_cnt = 0;
        apply_reset();
        @(negedge clk);
        drive_port(0, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0);
        drive_port(1, 1'b1, 1'b0, SIZE_B, 1'b0, 32'h20, 32'h0);
        f0_valid = 1'b1;
        f1_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (p0_resp_valid === 1'b1) order.push_back(0);
            if (p1_resp_valid === 1'b1) order.push_back(1);
            if (f0_resp_valid === 1'b1) f0_cnt++;
            if (f1_resp_valid === 1'b1) f1_cnt++;
            checks++;
            if ((p0_req_ready && p1_req_ready) !== 1'b0 || (p0_resp_valid && p1_resp_valid) !== 1'b0) begin
                errors++;
                $display("FAIL dual_grant: ready=%b resp=%b, required at most one", {p1_req_ready, p0_req_ready}, {p1_resp_valid, p0_resp_valid});
            end
        end
        drive_port(0, 1'b0, 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0);
        drive_port(1, 1'b0, 1'b0, SIZE_B, 1'b0, 32'h20, 32'h0);
        f0_valid = 1'b0;
        f1_valid = 1'b0;
        checks++;
        if (order.size() != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d responses in 12 cycles, required 4", order.size());
        end
        for (int i = 0; i < order.size() && i < 4; i++) begin
            checks++;
            if (order[i] != i % 2) begin
                errors++;
                $display("FAIL rr_order: response %0d went to port%0d, required port%0d", i, order[i], i % 2);
            end
        end
        checks++;
        if (f0_cnt != 4 || f1_cnt != 0) begin
            errors++;
            $display("FAIL fixed_prio: p0 %0d p1 %0d responses, required 4 and 0", f0_cnt, f1_cnt);
        end
        checks++;
        if (f_ram_we !== 3'b000) begin
            errors++;
            $display("FAIL fixed_prio_we: got %b, required 000", f_ram_we);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_errors();
        logic e; logic [31:0] d;
        run_txn(0, 1'b0, SIZE_W, 1'b0, 32'h7FE, 32'h0, e, d);
        run_txn(1, 1'b0, SIZE_H, 1'b0, 32'h11, 32'h0, e, d);
        run_txn(0, 1'b1, SIZE_ILL, 1'b0, 32'h40, 32'h12345678, e, d);
        run_txn(1, 1'b1, SIZE_W, 1'b0, 32'hFFFFFFFC, 32'hA5A5A5A5, e, d);
        run_txn(0, 1'b1, SIZE_H, 1'b0, 32'h800, 32'h1234, e, d);
        run_txn(0, 1'b1, SIZE_W, 1'b0, 32'h7FC, 32'h01020304, e, d);
        run_txn(1, 1'b0, SIZE_B, 1'b1, 32'h7FF, 32'h0, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'h4) begin
            errors++;
            $display("FAIL top_byte: err=%b rdata=%h, required 0 and 00000004", e, d);
        end
        check_mem("errors");
    endtask

    task automatic test_gpio();
        logic e; logic [31:0] d;
        run_txn(1, 1'b1, SIZE_B, 1'b0, GPIO_ADDR, 32'h5A, e, d);
        checks++;
        if (ram[GPIO_ADDR[10:0]] !== 8'h5A) begin
            errors++;
            $display("FAIL gpio_byte: ram holds %h, required 5a", ram[GPIO_ADDR[10:0]]);
        end
        run_txn(0, 1'b0, SIZE_B, 1'b0, GPIO_ADDR, 32'h0, e, d);
        checks++;
        if (d !== 32'h5A) begin
            errors++;
            $display("FAIL gpio_read: got %h, required 0000005a", d);
        end
    endtask

    task automatic test_reset_mid_access();
        int waited = 0;
        @(negedge clk);
        drive_port(0, 1'b1, 1'b1, SIZE_W, 1'b0, 32'h20, 32'hCAFEF00D);
        #1;
        checks++;
        if (p0_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready: p0 ready %b, required 1", p0_req_ready);
        end
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b1, SIZE_W, 1'b0, 32'h20, 32'hCAFEF00D);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ram_we !== 3'b000 || p0_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: ram_we=%b resp=%b, required 000 and 0", ram_we, p0_resp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({p0_resp_valid, p1_resp_valid} !== 2'b00) begin
                errors++;
                $display("FAIL dropped_resp: resp %b after reset, required 00", {p1_resp_valid, p0_resp_valid});
            end
        end
        check_mem("mid_reset");
        drive_port(0, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h20, 32'h0);
        drive_port(1, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h24, 32'h0);
        #1;
        checks++;
        if ({p1_req_ready, p0_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_grant: ready %b, required 01", {p1_req_ready, p0_req_ready});
        end
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, SIZE_W, 1'b0, 32'h20, 32'h0);
        while (p1_req_ready !== 1'b1 && waited < 8) begin
            @(negedge clk); #1; waited++;
        end
        checks++;
        if (waited >= 8) begin
            errors++;
            $display("FAIL p1_timeout: p1 ready stayed 0, required 1");
        end
        @(posedge clk); #1;
        drive_port(1, 1'b0, 1'b0, SIZE_W, 1'b0, 32'h24, 32'h0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        logic e; logic [31:0] d, a;
        logic [1:0] sz;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: a = 32'($urandom_range(0, MEM - 1));
                1: a = 32'(MEM - 4 + $urandom_range(0, 7));
                2: a = $urandom();
                default: a = GPIO_ADDR + 32'($urandom_range(0, 7));
            endcase
            sz = 2'($urandom_range(0, 3));
            run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                    a, $urandom(), e, d);
        end
    endtask

    initial begin
        for (int i = 0; i < MEM; i++) begin
            ram[i] = 8'($urandom());
            ref_mem[i] = ram[i];
        end
        test_reset();
        test_word_write_read();
        test_byte_half();
        test_arbitration();
        test_errors();
        test_gpio();
        test_reset_mid_access();
        test_random();
        check_mem("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
